// File: rtl/ex_wb_pipe.sv
// EX stage plus EX/MEM and MEM/WB registers: forwarding, load-use stall, branch/jal redirect, counters.
// Latency: memory access 1 cycle after EX, register write 2 cycles; no backpressure, the decoder bubbles on stall/pcsrc.
module ex_wb_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ctrl,
   input  logic [31:0] imm,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_rs1_data,
   input  logic [31:0] ex_rs2_data,
   input  logic [4:0]  ex_rs1,
   input  logic [4:0]  ex_rs2,
   input  logic [4:0]  ex_rd,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [31:0] mem_rdata,
   output logic        pcsrc,
   output logic [31:0] pc_target,
   output logic        stall,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [31:0] retire_cnt,
   output logic [31:0] stall_cnt
);

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic        regwrite;
      logic [1:0]  regsrc;
      logic        memread;
      logic        memwrite;
      logic        valid;
   } exmem_t;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        regwrite;
      logic        valid;
   } memwb_t;

   exmem_t      exm, exm_d;
   memwb_t      mwb, mwb_d;
   logic        exm_fwd_ok;
   logic [31:0] rs1_fwd, rs2_fwd, opa, opb, alu;

   logic unused_ctrl;
   assign unused_ctrl = &{1'b0, ctrl[31:19], ctrl[15:14], ctrl[11:10], ctrl[7:6]};

   // Loads in EX/MEM are excluded: their data is not available until MEM/WB.
   assign exm_fwd_ok = exm.regwrite && (exm.rd != 5'd0) && (exm.regsrc == 2'b00);

   always_comb begin
      rs1_fwd = ex_rs1_data;
      if (exm_fwd_ok && (exm.rd == ex_rs1))
         rs1_fwd = exm.result;
      else if (wb_we && (wb_rd == ex_rs1))
         rs1_fwd = wb_data;

      rs2_fwd = ex_rs2_data;
      if (exm_fwd_ok && (exm.rd == ex_rs2))
         rs2_fwd = exm.result;
      else if (wb_we && (wb_rd == ex_rs2))
         rs2_fwd = wb_data;
   end

   assign opa = ctrl[5] ? rs1_fwd : ex_rs1_data;
   assign opb = ctrl[4] ? imm : rs2_fwd;

   always_comb begin
      case (ctrl[3:0])
         4'b0010: alu = opa + opb;
         4'b0001: alu = opa - opb;
         default: alu = 32'd0;
      endcase
   end

   assign pcsrc     = ctrl[9] | (ctrl[8] & (opa == opb));
   assign pc_target = ex_pc + {imm[30:0], 1'b0};
   assign stall     = ctrl[13] & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

   always_comb begin
      exm_d          = '0;
      exm_d.result   = ctrl[9] ? (ex_pc + 32'd4) : alu;
      exm_d.wdata    = rs2_fwd;
      exm_d.rd       = ex_rd;
      exm_d.regwrite = ctrl[18];
      exm_d.regsrc   = ctrl[17:16];
      exm_d.memread  = ctrl[13];
      exm_d.memwrite = ctrl[12];
      exm_d.valid    = ctrl[18] | ctrl[12] | ctrl[8] | ctrl[9];
   end

   always_comb begin
      mwb_d          = '0;
      mwb_d.data     = (exm.regsrc == 2'b01) ? mem_rdata : exm.result;
      mwb_d.rd       = exm.rd;
      mwb_d.regwrite = exm.regwrite;
      mwb_d.valid    = exm.valid;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         exm        <= '0;
         mwb        <= '0;
         retire_cnt <= 32'd0;
         stall_cnt  <= 32'd0;
      end else begin
         exm <= exm_d;
         mwb <= mwb_d;
         if (mwb.valid)
            retire_cnt <= retire_cnt + 32'd1;
         if (stall)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign mem_addr  = exm.result;
   assign mem_wdata = exm.wdata;
   assign mem_we    = exm.memwrite;
   assign mem_re    = exm.memread;
   assign wb_we     = mwb.regwrite & (mwb.rd != 5'd0);
   assign wb_rd     = mwb.rd;
   assign wb_data   = mwb.data;

endmodule

// File: tb/tb_ex_wb_pipe.sv
// Bench for ex_wb_pipe: acts as decoder, register file and data memory around the DUT and checks
// write-back, store and load traffic against an instruction-level model through queues.
module tb_ex_wb_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ctrl, imm, ex_pc, ex_rs1_data, ex_rs2_data, mem_rdata;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd, id_rs1, id_rs2;
   logic        pcsrc, stall, mem_we, mem_re, wb_we;
   logic [31:0] pc_target, mem_addr, mem_wdata, wb_data, retire_cnt, stall_cnt;
   logic [4:0]  wb_rd;

   always #5 clk = ~clk;

   ex_wb_pipe dut (
      .clk(clk), .rst(rst), .ctrl(ctrl), .imm(imm), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .mem_rdata(mem_rdata), .pcsrc(pcsrc), .pc_target(pc_target), .stall(stall),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
   );

   localparam logic [31:0] IGN = 32'hFFF8_CCC0;

   typedef enum int {K_BUB, K_ADD, K_SUB, K_ZERO, K_ADDI, K_RAWA, K_LD, K_ST, K_BEQ, K_JAL} kind_e;
   typedef struct {
      kind_e       kind;
      logic [31:0] ctrl, imm, pc, a_raw;
      logic [4:0]  rs1, rs2, rd;
   } ins_t;
   typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
   typedef struct { logic [31:0] addr, data; } st_t;

   wr_t         wq[$];
   st_t         sq[$];
   logic [31:0] lq[$];
   ins_t        prog[$];

   int checks = 0;
   int failures = 0;
   int exp_retire, exp_stall;

   // Architectural model state, updated in program order at issue.
   logic [31:0] x[32];
   logic [31:0] amem[16];
   // Environment: register file and data memory written by the DUT.
   logic [31:0] rf[32];
   logic [31:0] dmem[16];

   ins_t        cur, nxt;
   logic [31:0] nxt_d1, nxt_d2;
   bit          bubble_now;
   wr_t         mw;
   st_t         ms;
   logic [31:0] ml;

   assign mem_rdata = dmem[mem_addr[5:2]];

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
         for (int i = 0; i < 16; i++) dmem[i] <= 32'd0;
      end else begin
         if (wb_we) rf[wb_rd] <= wb_data;
         if (mem_we) dmem[mem_addr[5:2]] <= mem_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (wb_we) begin
            if (wq.size() == 0) begin
               checks++; failures++;
               $display("FAIL wb_unexpected: got write rd=%0d data=%h, expected none", wb_rd, wb_data);
            end else begin
               mw = wq.pop_front();
               chk("wb_rd", 32'(wb_rd), 32'(mw.rd));
               chk("wb_data", wb_data, mw.data);
            end
         end
         if (mem_we) begin
            if (sq.size() == 0) begin
               checks++; failures++;
               $display("FAIL store_unexpected: got addr=%h data=%h, expected none", mem_addr, mem_wdata);
            end else begin
               ms = sq.pop_front();
               chk("store_addr", mem_addr, ms.addr);
               chk("store_data", mem_wdata, ms.data);
            end
         end
         if (mem_re) begin
            if (lq.size() == 0) begin
               checks++; failures++;
               $display("FAIL load_unexpected: got addr=%h, expected none", mem_addr);
            end else begin
               ml = lq.pop_front();
               chk("load_addr", mem_addr, ml);
            end
         end
      end
   end

   function automatic logic [31:0] mkc(bit rw, logic [1:0] rs, bit mr, bit mwr, bit j, bit br,
                                       bit fa, bit bs, logic [3:0] op);
      return {13'd0, rw, rs, 2'b00, mr, mwr, 2'b00, j, br, 2'b00, fa, bs, op};
   endfunction

   function automatic logic [31:0] ctrl_for(kind_e k);
      logic [31:0] c;
      logic [3:0]  op;
      case (k)
         K_ADD:  c = mkc(1, 2'b00, 0, 0, 0, 0, 1, 0, 4'b0010);
         K_SUB:  c = mkc(1, 2'b00, 0, 0, 0, 0, 1, 0, 4'b0001);
         K_ZERO: begin
            do op = 4'($urandom_range(0, 15)); while (op == 4'd1 || op == 4'd2);
            c = mkc(1, 2'b00, 0, 0, 0, 0, 1, 0, op);
         end
         K_ADDI: c = mkc(1, 2'b00, 0, 0, 0, 0, 1, 1, 4'b0010);
         K_RAWA: c = mkc(1, 2'b00, 0, 0, 0, 0, 0, 1, 4'b0010);
         K_LD:   c = mkc(1, 2'b01, 1, 0, 0, 0, 1, 1, 4'b0010);
         K_ST:   c = mkc(0, 2'b00, 0, 1, 0, 0, 1, 1, 4'b0010);
         K_BEQ:  c = mkc(0, 2'b00, 0, 0, 0, 1, 1, 0, 4'($urandom_range(0, 15)));
         K_JAL:  c = mkc(1, 2'b00, 0, 0, 1, 0, 1'($urandom_range(0, 1)), 1, 4'b0010);
         default: return 32'd0;
      endcase
      return c | ($urandom & IGN);
   endfunction

   function automatic ins_t mk_ins(kind_e k, int rd, int rs1, int rs2, logic [31:0] im, logic [31:0] pc);
      ins_t i;
      i.kind = k; i.ctrl = ctrl_for(k); i.imm = im; i.pc = pc; i.a_raw = $urandom;
      i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
      return i;
   endfunction

   function automatic ins_t gen();
      kind_e k;
      if ($urandom_range(0, 19) == 0) k = K_BUB;
      else k = kind_e'($urandom_range(1, 9));
      if (k == K_LD || k == K_ST)
         return mk_ins(k, $urandom_range(0, 7), 0, $urandom_range(0, 7),
                       32'($urandom_range(0, 15) * 4), $urandom & ~32'd3);
      return mk_ins(k, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom, $urandom & ~32'd3);
   endfunction

   function automatic ins_t next_prog();
      if (prog.size() > 0) return prog.pop_front();
      return gen();
   endfunction

   function automatic logic [31:0] rdrf(logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_we && wb_rd == r) return wb_data;
      return rf[r];
   endfunction

   task automatic prep();
      nxt_d1 = (nxt.kind == K_RAWA) ? nxt.a_raw : rdrf(nxt.rs1);
      nxt_d2 = rdrf(nxt.rs2);
   endtask

   task automatic drive(input ins_t i, input logic [31:0] d1, input logic [31:0] d2);
      ctrl = i.ctrl; imm = i.imm; ex_pc = i.pc;
      ex_rs1 = i.rs1; ex_rs2 = i.rs2; ex_rd = i.rd;
      ex_rs1_data = d1; ex_rs2_data = d2;
   endtask

   task automatic wr(input logic [4:0] rd, input logic [31:0] v);
      wr_t e;
      if (rd != 5'd0) begin
         x[rd] = v;
         e.rd = rd; e.data = v;
         wq.push_back(e);
      end
   endtask

   // Instruction-level semantics: results computed from architectural state in program order.
   task automatic model(input ins_t i, output bit taken, output logic [31:0] tgt);
      logic [31:0] addr;
      st_t         s;
      taken = 0;
      tgt   = i.pc + i.imm * 2;
      case (i.kind)
         K_ADD:  wr(i.rd, x[i.rs1] + x[i.rs2]);
         K_SUB:  wr(i.rd, x[i.rs1] - x[i.rs2]);
         K_ZERO: wr(i.rd, 32'd0);
         K_ADDI: wr(i.rd, x[i.rs1] + i.imm);
         K_RAWA: wr(i.rd, i.a_raw + i.imm);
         K_LD: begin
            addr = x[i.rs1] + i.imm;
            lq.push_back(addr);
            wr(i.rd, amem[addr[5:2]]);
         end
         K_ST: begin
            addr = x[i.rs1] + i.imm;
            amem[addr[5:2]] = x[i.rs2];
            s.addr = addr; s.data = x[i.rs2];
            sq.push_back(s);
         end
         K_BEQ:  taken = (x[i.rs1] == x[i.rs2]);
         K_JAL: begin
            taken = 1;
            wr(i.rd, i.pc + 4);
         end
         default: ;
      endcase
      if (i.kind != K_BUB) exp_retire++;
   endtask

   task automatic slot();
      bit          taken, exp_st;
      logic [31:0] tgt;
      @(negedge clk);
      if (bubble_now) begin
         cur = mk_ins(K_BUB, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom, 0);
         drive(cur, $urandom, $urandom);
      end else begin
         cur = nxt;
         drive(cur, nxt_d1, nxt_d2);
         nxt = next_prog();
      end
      id_rs1 = nxt.rs1; id_rs2 = nxt.rs2;
      #1;
      model(cur, taken, tgt);
      exp_st = (cur.kind == K_LD) && (cur.rd != 0) && (cur.rd == nxt.rs1 || cur.rd == nxt.rs2);
      if (exp_st) exp_stall++;
      chk("pcsrc", 32'(pcsrc), 32'(taken));
      if (taken) chk("pc_target", pc_target, tgt);
      chk("stall", 32'(stall), 32'(exp_st));
      if (taken) begin
         nxt = next_prog();
         bubble_now = 1;
      end else begin
         bubble_now = exp_st;
      end
      prep();
   endtask

   task automatic reset_model();
      for (int i = 0; i < 32; i++) x[i] = 32'd0;
      for (int i = 0; i < 16; i++) amem[i] = 32'd0;
      exp_retire = 0; exp_stall = 0;
      wq.delete(); sq.delete(); lq.delete(); prog.delete();
      bubble_now = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wb_we"}, 32'(wb_we), 32'd0);
      chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
      chk({tag, "_wb_data"}, wb_data, 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_re"}, 32'(mem_re), 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_retire_cnt"}, retire_cnt, 32'd0);
      chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
      chk({tag, "_pcsrc"}, 32'(pcsrc), 32'd0);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
   endtask

   task automatic drain_and_check(input string tag);
      for (int i = 0; i < 12; i++) prog.push_back(mk_ins(K_BUB, 0, 0, 0, 0, 0));
      repeat (8) slot();
      chk({tag, "_wq_left"}, 32'(wq.size()), 32'd0);
      chk({tag, "_sq_left"}, 32'(sq.size()), 32'd0);
      chk({tag, "_lq_left"}, 32'(lq.size()), 32'd0);
      chk({tag, "_retire_cnt"}, retire_cnt, 32'(exp_retire));
      chk({tag, "_stall_cnt"}, stall_cnt, 32'(exp_stall));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(mk_ins(K_BUB, 0, 0, 0, 0, 0), 32'd0, 32'd0);
      id_rs1 = 5'd0; id_rs2 = 5'd0;
      @(negedge clk);
      #1;
   endtask

   task automatic release_reset();
      reset_model();
      rst = 1'b1;
      nxt = next_prog();
      prep();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      reset_model();
      apply_reset();
      check_reset_outputs("reset");

      // Directed scenarios first, then randomized traffic.
      prog.push_back(mk_ins(K_ADDI, 1, 0, 0, 32'd5, 0));
      prog.push_back(mk_ins(K_ADD, 2, 1, 1, 0, 0));
      prog.push_back(mk_ins(K_ST, 0, 0, 1, 32'd8, 0));
      prog.push_back(mk_ins(K_LD, 3, 0, 0, 32'd8, 0));
      prog.push_back(mk_ins(K_ADD, 4, 3, 0, 0, 0));
      prog.push_back(mk_ins(K_BEQ, 0, 1, 1, 32'd4, 32'h40));
      prog.push_back(mk_ins(K_ADDI, 5, 0, 0, 32'd99, 0));
      prog.push_back(mk_ins(K_BEQ, 0, 1, 2, 32'd4, 32'h80));
      prog.push_back(mk_ins(K_JAL, 1, 0, 0, 32'h10, 32'h100));
      prog.push_back(mk_ins(K_ADD, 6, 1, 0, 0, 0));
      prog.push_back(mk_ins(K_ADDI, 0, 0, 0, 32'd7, 0));
      prog.push_back(mk_ins(K_ADD, 7, 0, 0, 0, 0));
      release_reset();
      repeat (400) slot();
      drain_and_check("phase1");

      repeat (3) slot();
      apply_reset();
      check_reset_outputs("midreset");
      release_reset();
      repeat (200) slot();
      drain_and_check("phase2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
